// File: rtl/core_mem_ctl_pkg.sv
// Shared types and constants for the core-memory controller: FSM states,
// word width and default access/rewrite/recovery timings at 100 MHz.
package core_mem_pkg;

  localparam int WORD_W      = 36;
  localparam int TMR_W       = 8;
  localparam int DEF_AW      = 12;
  localparam int DEF_ACK_CYC = 20;
  localparam int DEF_RD_CYC  = 40;
  localparam int DEF_WR_CYC  = 40;
  localparam int DEF_REC_CYC = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_READ    = 3'd2,
    ST_WAITWR  = 3'd3,
    ST_WRITE   = 3'd4,
    ST_RECOVER = 3'd5
  } state_e;

  // A phase of N clocks expires N edges after the load, so the counter starts at N-1.
  function automatic logic [TMR_W-1:0] tmr_val(input int cyc);
    return TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/core_mem_ctl_if.sv
// Memory-bus signals between the processor pulse logic (master) and the
// core-memory controller (slave).
interface core_mem_ctl_if #(
  parameter int AW = 12
);
  import core_mem_pkg::*;

  logic              rq_cyc;
  logic              rd_rq;
  logic              wr_rq;
  logic [AW-1:0]     addr;
  logic              wr_rs;
  logic [WORD_W-1:0] mb_in;
  logic              addr_ack;
  logic              rd_rs;
  logic [WORD_W-1:0] mb_out;
  logic              busy;

  modport master (
    output rq_cyc, rd_rq, wr_rq, addr, wr_rs, mb_in,
    input  addr_ack, rd_rs, mb_out, busy
  );

  modport slave (
    input  rq_cyc, rd_rq, wr_rq, addr, wr_rs, mb_in,
    output addr_ack, rd_rs, mb_out, busy
  );

endinterface

// File: rtl/core_mem_ctl_timer.sv
// Loadable down-counter: after a load of V it raises expire_o for exactly one
// clock, V+1 clocks later, then stays quiet until the next load.
module cyc_timer
  import core_mem_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  assign expire_o = active_q & (cnt_q == '0);

  // Next count: a load wins over expiry so back-to-back phases chain cleanly.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = load_val_i;
      active_d = 1'b1;
    end else if (expire_o) begin
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q - TMR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/core_mem_ctl.sv
// Core-memory module controller: emulates access, destructive read, rewrite
// and recovery timing of a 36-bit core stack behind the memory-bus pulse logic.
module core_mem_ctl
  import core_mem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int ACK_CYC = DEF_ACK_CYC,
  parameter int RD_CYC  = DEF_RD_CYC,
  parameter int WR_CYC  = DEF_WR_CYC,
  parameter int REC_CYC = DEF_REC_CYC
) (
  input logic           clk,
  input logic           reset,
  core_mem_ctl_if.slave bus
);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_l_q;
  logic              rd_l_q;
  logic              wr_l_q;
  logic [WORD_W-1:0] data_q;
  logic              addr_ack_q;
  logic              rd_rs_q;
  logic [WORD_W-1:0] mb_out_q;
  logic              busy_q;

  logic [WORD_W-1:0] mem_q [2**AW];
  logic [WORD_W-1:0] rdata_q;

  logic              accept_s;
  logic              tmr_load_s;
  logic [TMR_W-1:0]  tmr_val_s;
  logic              tmr_exp_s;
  logic              mem_we_s;
  logic [WORD_W-1:0] mem_wd_s;

  assign accept_s = bus.rq_cyc & (bus.rd_rq | bus.wr_rq);

  cyc_timer u_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .expire_o   (tmr_exp_s)
  );

  // Next state, timer reload on state entry, and array write strobes.
  always_comb begin
    state_d    = state_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    mem_we_s   = 1'b0;
    mem_wd_s   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_ACK;
          tmr_load_s = 1'b1;
          tmr_val_s  = tmr_val(ACK_CYC);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (tmr_exp_s) begin
          state_d    = ST_READ;
          tmr_load_s = 1'b1;
          tmr_val_s  = tmr_val(RD_CYC);
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_READ: begin
        if (tmr_exp_s) begin
          mem_we_s = 1'b1;
          if (wr_l_q) begin
            state_d = ST_WAITWR;
          end else begin
            // Plain rewrite begins the cycle after rd_rs, hence one extra count.
            state_d    = ST_WRITE;
            tmr_load_s = 1'b1;
            tmr_val_s  = TMR_W'(WR_CYC);
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WAITWR: begin
        if (bus.wr_rs || !bus.rq_cyc) begin
          state_d    = ST_WRITE;
          tmr_load_s = 1'b1;
          tmr_val_s  = tmr_val(WR_CYC);
        end else begin
          state_d = ST_WAITWR;
        end
      end
      ST_WRITE: begin
        if (tmr_exp_s) begin
          mem_we_s   = 1'b1;
          mem_wd_s   = data_q;
          state_d    = ST_RECOVER;
          tmr_load_s = 1'b1;
          tmr_val_s  = tmr_val(REC_CYC);
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_RECOVER: begin
        if (tmr_exp_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, request latches, data register and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_l_q   <= '0;
      rd_l_q     <= 1'b0;
      wr_l_q     <= 1'b0;
      data_q     <= '0;
      addr_ack_q <= 1'b0;
      rd_rs_q    <= 1'b0;
      mb_out_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_ack_q <= 1'b0;
      rd_rs_q    <= 1'b0;
      busy_q     <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            addr_l_q <= bus.addr;
            rd_l_q   <= bus.rd_rq;
            wr_l_q   <= bus.wr_rq;
          end
        end
        ST_ACK: begin
          if (tmr_exp_s) begin
            addr_ack_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (tmr_exp_s) begin
            data_q <= rdata_q;
            if (rd_l_q) begin
              rd_rs_q  <= 1'b1;
              mb_out_q <= rdata_q;
            end
          end
        end
        ST_WAITWR: begin
          if (bus.wr_rs) begin
            data_q <= bus.mb_in;
          end
        end
        default: begin
          data_q <= data_q;
        end
      endcase
    end
  end

  // Single-port read-first array; its address is held for the whole cycle,
  // so rdata_q is settled long before the read strobe. Reset drops a pending write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_q[addr_l_q] <= mem_wd_s;
    end
    rdata_q <= mem_q[addr_l_q];
  end

  assign bus.addr_ack = addr_ack_q;
  assign bus.rd_rs    = rd_rs_q;
  assign bus.mb_out   = mb_out_q;
  assign bus.busy     = busy_q;

endmodule
